// File: rtl/light_mode_sequencer.sv
// Bike light mode controller: OFF/ON/BLINK/STROBE stepping on button pulses,
// with beat-driven pattern phase and a restart pulse to beat32 on mode change.
module light_mode_sequencer #(
    parameter int BLINK_ON_BEATS = 16,
    parameter int STROBE_PERIOD  = 8,
    parameter int STROBE_ON      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       beat,
    input  logic       next,
    input  logic       off,
    output logic       restart,
    output logic [1:0] mode,
    output logic [4:0] phase,
    output logic       light
);

    localparam logic [1:0] M_OFF    = 2'd0;
    localparam logic [1:0] M_ON     = 2'd1;
    localparam logic [1:0] M_BLINK  = 2'd2;
    localparam logic [1:0] M_STROBE = 2'd3;

    localparam logic [5:0] BLINK_LIM  = 6'(BLINK_ON_BEATS);
    localparam logic [5:0] STROBE_LIM = 6'(STROBE_ON);
    localparam logic [4:0] STROBE_MSK = 5'(STROBE_PERIOD - 1);

    logic [1:0] r_mode;
    logic [4:0] r_phase;
    logic       r_light;
    logic       r_restart;

    logic [1:0] w_mode_nxt;
    logic [4:0] w_phase_nxt;
    logic       w_change;
    logic       w_light_nxt;
    logic [4:0] w_strobe_pos;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode    <= M_OFF;
            r_phase   <= 5'd0;
            r_light   <= 1'b0;
            r_restart <= 1'b0;
        end else begin
            r_mode    <= w_mode_nxt;
            r_phase   <= w_phase_nxt;
            r_light   <= w_light_nxt;
            r_restart <= w_change;
        end
    end

    // off outranks next; a mode change always zeroes phase and drops the beat
    always_comb begin
        w_mode_nxt  = r_mode;
        w_phase_nxt = r_phase;
        if (off) begin
            w_mode_nxt = M_OFF;
        end else if (next) begin
            w_mode_nxt = r_mode + 2'd1;
        end
        w_change = (w_mode_nxt != r_mode);
        if (w_change) begin
            w_phase_nxt = 5'd0;
        end else if (r_mode == M_OFF || r_mode == M_ON) begin
            w_phase_nxt = 5'd0;
        end else if (beat) begin
            w_phase_nxt = r_phase + 5'd1;
        end
    end

    // Light is derived from next-state so it lines up with mode/phase
    always_comb begin
        w_light_nxt  = 1'b0;
        w_strobe_pos = w_phase_nxt & STROBE_MSK;
        case (w_mode_nxt)
            M_OFF:    w_light_nxt = 1'b0;
            M_ON:     w_light_nxt = 1'b1;
            M_BLINK:  w_light_nxt = ({1'b0, w_phase_nxt} < BLINK_LIM);
            M_STROBE: w_light_nxt = ({1'b0, w_strobe_pos} < STROBE_LIM);
            default:  w_light_nxt = 1'b0;
        endcase
    end

    assign restart = r_restart;
    assign mode    = r_mode;
    assign phase   = r_phase;
    assign light   = r_light;

endmodule
